multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// Main control FSM for the multicycle MIPS datapath. Sequences each instruction through
// fetch/decode/execute/memory/writeback, drives all datapath mux selects and write enables,
// and produces the 2-bit ALUOp consumed by the ALU decoder (00 add, 01 sub, 1x funct-driven).
// Supports lw, sw, R-type, beq, addi and j. Also keeps a retired-instruction count.
// PARAMETERS
// CNT_W    32  width of the InstrCount retired-instruction counter (wraps modulo 2^CNT_W)
// ILL_TRAP 0   1: an illegal opcode holds the FSM in ILLEGAL until reset; 0: return to FETCH
// PORTS
// clk         in   1      rising-edge clock
// reset_n     in   1      synchronous reset, active-low
// Op          in   6      opcode Instr[31:26] from the instruction register
// Zero        in   1      ALU zero flag
// MemtoReg    out  1      register write data: 1=memory data, 0=ALUOut
// RegDst      out  1      destination register: 1=rd, 0=rt
// IorD        out  1      memory address: 1=ALUOut, 0=PC
// PCSrc       out  2      next PC: 00=ALUResult, 01=ALUOut, 10=jump target
// ALUSrcB     out  2      ALU B: 00=RD2, 01=const 4, 10=SignImm, 11=SignImm<<2
// ALUSrcA     out  1      ALU A: 0=PC, 1=RD1
// ALUOp       out  2      to ALU decoder
// IRWrite     out  1      load instruction register
// MemWrite    out  1      memory write strobe
// RegWrite    out  1      register file write strobe
// PCEn        out  1      PC load = PCWrite | (Branch & Zero)
// Illegal     out  1      1 for exactly one cycle per illegal opcode decoded (sticky if ILL_TRAP=1)
// InstrCount  out  CNT_W  count of completed instructions
// BEHAVIOUR
// - Clock and reset: single clk; reset is synchronous and active-low (reset_n sampled on the rising edge).
// - Reset: state<=FETCH, InstrCount<=0. While reset_n=0, IRWrite/MemWrite/RegWrite/PCEn/Illegal
//   are forced to 0; select outputs show FETCH values.
// - Moore outputs decoded combinationally from the state register; next state uses Op/Zero.
// - Any output not listed for a state below is 0.
// - States and outputs:
//   FETCH   : IorD=0 SrcA=0 SrcB=01 ALUOp=00 PCSrc=00 IRWrite=1 PCWrite=1 -> DECODE
//   DECODE  : SrcA=0 SrcB=11 ALUOp=00 (branch target precompute)
//   MEMADR  : SrcA=1 SrcB=10 ALUOp=00 -> MEMRD if Op=lw, MEMWR if Op=sw
//   MEMRD   : IorD=1 -> MEMWB
//   MEMWB   : RegDst=0 MemtoReg=1 RegWrite=1 -> FETCH
//   MEMWR   : IorD=1 MemWrite=1 -> FETCH
//   EXECUTE : SrcA=1 SrcB=00 ALUOp=10 -> ALUWB
//   ALUWB   : RegDst=1 MemtoReg=0 RegWrite=1 -> FETCH
//   BRANCH  : SrcA=1 SrcB=00 ALUOp=01 PCSrc=01 Branch=1 -> FETCH
//   ADDIEX  : SrcA=1 SrcB=10 ALUOp=00 -> ADDIWB
//   ADDIWB  : RegDst=0 MemtoReg=0 RegWrite=1 -> FETCH
//   JUMP    : PCSrc=10 PCWrite=1 -> FETCH
//   ILLEGAL : Illegal=1, no writes -> FETCH (ILL_TRAP=0) or stay (ILL_TRAP=1)
// - DECODE dispatch on Op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH,
//   001000->ADDIEX, 000010->JUMP, any other->ILLEGAL.
// - Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3 (ILL_TRAP=0).
// - Op is sampled only in DECODE and MEMADR; Op changes in other states have no effect.
// - PCEn in BRANCH = Zero of the current cycle; Zero is ignored in all other states.
// - InstrCount += 1 on each transition MEMWB/MEMWR/ALUWB/BRANCH/ADDIWB/JUMP -> FETCH
//   (beq counts whether taken or not); ILLEGAL does not count; wraps at all-ones -> 0.
// - Reset mid-instruction: the instruction is abandoned, no partial writeback occurs,
//   and the count is not incremented.
// - Unencoded state values -> FETCH on the next clock, with all write enables 0.
// TESTING
// - Reset with reset_n=0 for 2 clks, then release -> FETCH on cycle 0: IRWrite=1, PCEn=1,
//   SrcB=01, ALUOp=00; InstrCount=0.
// - lw (Op=100011) -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5;
//   InstrCount=1.
// - R-type (Op=000000) then sw (Op=101011) -> ALUOp=10 in EXECUTE; MemWrite=1 for exactly 1 cycle
//   in MEMWR; InstrCount=2.
// - beq with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH; beq with Zero=0 -> PCEn=0; both count.
// - j (Op=000010) -> PCEn=1 and PCSrc=10 in cycle 3; addi (Op=001000) -> RegWrite with RegDst=0
//   in cycle 4.
// - Op=111111 -> Illegal=1 for one cycle, then FETCH, count unchanged; reset_n=0 during MEMRD
//   of lw -> no RegWrite, FETCH next; CNT_W=4 with 16 instructions -> count wraps to 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath (slave).
// The master drives every datapath select and strobe; the slave returns the opcode and ALU zero flag.
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       Op;
   logic             Zero;
   logic             MemtoReg;
   logic             RegDst;
   logic             IorD;
   logic [1:0]       PCSrc;
   logic [1:0]       ALUSrcB;
   logic             ALUSrcA;
   logic [1:0]       ALUOp;
   logic             IRWrite;
   logic             MemWrite;
   logic             RegWrite;
   logic             PCEn;
   logic             Illegal;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      input  Op, Zero,
      output MemtoReg, RegDst, IorD, PCSrc, ALUSrcB, ALUSrcA, ALUOp,
             IRWrite, MemWrite, RegWrite, PCEn, Illegal, InstrCount
   );

   modport slave (
      output Op, Zero,
      input  MemtoReg, RegDst, IorD, PCSrc, ALUSrcB, ALUSrcA, ALUOp,
             IRWrite, MemWrite, RegWrite, PCEn, Illegal, InstrCount
   );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences lw/sw/R-type/beq/addi/j through
// fetch..writeback, decodes Moore controls from the state register and counts retired instructions.
module multicycle_controller #(
   parameter int CNT_W    = 32,
   parameter bit ILL_TRAP = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             retire;
   state_t           outState;

   logic       memtoReg, regDst, iorD, aluSrcA;
   logic [1:0] pcSrc, aluSrcB, aluOp;
   logic       irWrite, memWrite, regWrite, pcWrite, branch, illegal;

   // Next state and retirement; retire marks the final cycle of every legal instruction.
   always_comb begin
      state_d = FETCH;
      retire  = 1'b0;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = ILLEGAL;
            endcase
         end
         MEMADR:  state_d = (bus.Op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         ILLEGAL: state_d = ILL_TRAP ? ILLEGAL : FETCH;
         default: state_d = FETCH;
      endcase
      count_d = retire ? count_q + CNT_W'(1) : count_q;
   end

   // State and retired-instruction counter; a reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // While reset is held the selects present FETCH values even if the state register does not.
   assign outState = reset_n ? state_q : FETCH;

   always_comb begin
      memtoReg = 1'b0;
      regDst   = 1'b0;
      iorD     = 1'b0;
      aluSrcA  = 1'b0;
      pcSrc    = 2'b00;
      aluSrcB  = 2'b00;
      aluOp    = 2'b00;
      irWrite  = 1'b0;
      memWrite = 1'b0;
      regWrite = 1'b0;
      pcWrite  = 1'b0;
      branch   = 1'b0;
      illegal  = 1'b0;
      case (outState)
         FETCH: begin
            aluSrcB = 2'b01;
            irWrite = 1'b1;
            pcWrite = 1'b1;
         end
         DECODE:  aluSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
         end
         MEMRD:   iorD = 1'b1;
         MEMWB: begin
            memtoReg = 1'b1;
            regWrite = 1'b1;
         end
         MEMWR: begin
            iorD     = 1'b1;
            memWrite = 1'b1;
         end
         EXECUTE: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b10;
         end
         ALUWB: begin
            regDst   = 1'b1;
            regWrite = 1'b1;
         end
         BRANCH: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b01;
            pcSrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIWB:  regWrite = 1'b1;
         JUMP: begin
            pcSrc   = 2'b10;
            pcWrite = 1'b1;
         end
         ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end

   assign bus.MemtoReg   = memtoReg;
   assign bus.RegDst     = regDst;
   assign bus.IorD       = iorD;
   assign bus.ALUSrcA    = aluSrcA;
   assign bus.PCSrc      = pcSrc;
   assign bus.ALUSrcB    = aluSrcB;
   assign bus.ALUOp      = aluOp;
   assign bus.IRWrite    = reset_n & irWrite;
   assign bus.MemWrite   = reset_n & memWrite;
   assign bus.RegWrite   = reset_n & regWrite;
   assign bus.PCEn       = reset_n & (pcWrite | (branch & bus.Zero));
   assign bus.Illegal    = reset_n & illegal;
   assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors are queued when an
// opcode is applied and popped as the controller steps through each state.
module tb_multicycle_controller;

   localparam logic [3:0] T_FETCH   = 4'd0;
   localparam logic [3:0] T_DECODE  = 4'd1;
   localparam logic [3:0] T_MEMADR  = 4'd2;
   localparam logic [3:0] T_MEMRD   = 4'd3;
   localparam logic [3:0] T_MEMWB   = 4'd4;
   localparam logic [3:0] T_MEMWR   = 4'd5;
   localparam logic [3:0] T_EXECUTE = 4'd6;
   localparam logic [3:0] T_ALUWB   = 4'd7;
   localparam logic [3:0] T_BRANCH  = 4'd8;
   localparam logic [3:0] T_ADDIEX  = 4'd9;
   localparam logic [3:0] T_ADDIWB  = 4'd10;
   localparam logic [3:0] T_JUMP    = 4'd11;
   localparam logic [3:0] T_ILLEGAL = 4'd12;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   typedef struct packed {
      logic [3:0]  st;
      logic [14:0] vec;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstA, rstB;
   logic [5:0]  opDrv;
   logic        zeroDrv;
   logic        useB;
   int          errors = 0;
   int          checks = 0;
   int          expCnt;
   exp_t        sb[$];

   multicycle_controller_if #(.CNT_W(32)) busA();
   multicycle_controller_if #(.CNT_W(4))  busB();

   assign busA.Op   = opDrv;
   assign busA.Zero = zeroDrv;
   assign busB.Op   = opDrv;
   assign busB.Zero = zeroDrv;

   multicycle_controller #(.CNT_W(32), .ILL_TRAP(1'b0)) dutA (
      .clk     (clk),
      .reset_n (rstA),
      .bus     (busA.master)
   );

   multicycle_controller #(.CNT_W(4), .ILL_TRAP(1'b1)) dutB (
      .clk     (clk),
      .reset_n (rstB),
      .bus     (busB.master)
   );

   always #5 clk = ~clk;

   wire [14:0] obsA = {busA.MemtoReg, busA.RegDst, busA.IorD, busA.PCSrc, busA.ALUSrcB,
                       busA.ALUSrcA, busA.ALUOp, busA.IRWrite, busA.MemWrite, busA.RegWrite,
                       busA.PCEn, busA.Illegal};
   wire [14:0] obsB = {busB.MemtoReg, busB.RegDst, busB.IorD, busB.PCSrc, busB.ALUSrcB,
                       busB.ALUSrcA, busB.ALUOp, busB.IRWrite, busB.MemWrite, busB.RegWrite,
                       busB.PCEn, busB.Illegal};
   wire [14:0] obs  = useB ? obsB : obsA;
   wire [31:0] obsCnt = useB ? {28'd0, busB.InstrCount} : busA.InstrCount;

   // Reference control vector for each state, straight from the state/output table.
   function automatic logic [14:0] expVec(input logic [3:0] st, input logic z);
      logic mtr, rd, iord, srca, irw, mw, rw, pcen, ill;
      logic [1:0] pcsrc, srcb, aluop;
      {mtr, rd, iord, srca, irw, mw, rw, pcen, ill} = '0;
      {pcsrc, srcb, aluop} = '0;
      case (st)
         T_FETCH:   begin srcb = 2'b01; irw = 1'b1; pcen = 1'b1; end
         T_DECODE:  srcb = 2'b11;
         T_MEMADR:  begin srca = 1'b1; srcb = 2'b10; end
         T_MEMRD:   iord = 1'b1;
         T_MEMWB:   begin mtr = 1'b1; rw = 1'b1; end
         T_MEMWR:   begin iord = 1'b1; mw = 1'b1; end
         T_EXECUTE: begin srca = 1'b1; aluop = 2'b10; end
         T_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
         T_BRANCH:  begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; end
         T_ADDIEX:  begin srca = 1'b1; srcb = 2'b10; end
         T_ADDIWB:  rw = 1'b1;
         T_JUMP:    begin pcsrc = 2'b10; pcen = 1'b1; end
         T_ILLEGAL: ill = 1'b1;
         default: ;
      endcase
      return {mtr, rd, iord, pcsrc, srcb, srca, aluop, irw, mw, rw, pcen, ill};
   endfunction

   function automatic bit isLegal(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_J);
   endfunction

   task automatic pushState(input logic [3:0] st, input logic z);
      exp_t e;
      e.st  = st;
      e.vec = expVec(st, z);
      sb.push_back(e);
   endtask

   task automatic pushSequence(input logic [5:0] op, input logic z);
      pushState(T_FETCH, z);
      pushState(T_DECODE, z);
      case (op)
         OP_LW:   begin pushState(T_MEMADR, z); pushState(T_MEMRD, z); pushState(T_MEMWB, z); end
         OP_SW:   begin pushState(T_MEMADR, z); pushState(T_MEMWR, z); end
         OP_R:    begin pushState(T_EXECUTE, z); pushState(T_ALUWB, z); end
         OP_BEQ:  pushState(T_BRANCH, z);
         OP_ADDI: begin pushState(T_ADDIEX, z); pushState(T_ADDIWB, z); end
         OP_J:    pushState(T_JUMP, z);
         default: pushState(T_ILLEGAL, z);
      endcase
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Pops one expected vector per clock; with scramble set, Op is corrupted once it is no longer sampled.
   task automatic drainQueue(input string tag, input bit scramble);
      exp_t e;
      int idx;
      idx = 0;
      while (sb.size() > 0) begin
         if (scramble && idx == 3) opDrv = OP_BAD;
         #1;
         e = sb.pop_front();
         checkOutput($sformatf("%s/st%0d", tag, e.st), {17'd0, obs}, {17'd0, e.vec});
         idx++;
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [5:0] op, input logic z, input bit scramble);
      opDrv   = op;
      zeroDrv = z;
      pushSequence(op, z);
      drainQueue(tag, scramble);
      if (isLegal(op)) expCnt++;
      checkOutput({tag, "/count"}, obsCnt, useB ? (expCnt & 32'hF) : expCnt);
   endtask

   initial begin
      rstA    = 1'b0;
      rstB    = 1'b0;
      opDrv   = OP_R;
      zeroDrv = 1'b0;
      useB    = 1'b0;
      expCnt  = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("resetHold", {17'd0, obs}, {17'd0, expVec(T_FETCH, 1'b0) & 15'h7FE0});
      rstA = 1'b1;
      #1;
      checkOutput("resetCount", obsCnt, 32'd0);

      applyStimulus("lw",      OP_LW,   1'b1, 1'b1);
      applyStimulus("rtype",   OP_R,    1'b1, 1'b1);
      applyStimulus("sw",      OP_SW,   1'b0, 1'b0);
      applyStimulus("beqTaken", OP_BEQ, 1'b1, 1'b0);
      applyStimulus("beqNot",  OP_BEQ,  1'b0, 1'b0);
      applyStimulus("j",       OP_J,    1'b0, 1'b0);
      applyStimulus("addi",    OP_ADDI, 1'b0, 1'b0);
      applyStimulus("illegal", OP_BAD,  1'b0, 1'b0);

      // Reset during MEMRD of a lw must not produce the MEMWB write.
      opDrv = OP_LW;
      pushState(T_FETCH, 1'b0);
      pushState(T_DECODE, 1'b0);
      pushState(T_MEMADR, 1'b0);
      drainQueue("lwAbort", 1'b0);
      rstA = 1'b0;
      #1;
      checkOutput("abortReset", {17'd0, obs}, {17'd0, expVec(T_FETCH, 1'b0) & 15'h7FE0});
      @(negedge clk);
      rstA   = 1'b1;
      expCnt = 0;
      #1;
      checkOutput("abortCount", obsCnt, 32'd0);
      applyStimulus("addiAfterAbort", OP_ADDI, 1'b0, 1'b0);

      // Narrow counter with trapping illegal opcodes.
      @(negedge clk);
      rstA   = 1'b0;
      useB   = 1'b1;
      expCnt = 0;
      rstB   = 1'b1;
      #1;
      checkOutput("wrapResetCount", obsCnt, 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus($sformatf("wrap%0d", i), (i % 2 == 0) ? OP_J : OP_BEQ, i[1], 1'b0);
      end
      checkOutput("wrapZero", obsCnt, 32'd0);

      opDrv = OP_BAD;
      pushState(T_FETCH, 1'b0);
      pushState(T_DECODE, 1'b0);
      repeat (4) pushState(T_ILLEGAL, 1'b0);
      drainQueue("trap", 1'b0);
      opDrv = OP_LW;
      pushState(T_ILLEGAL, 1'b0);
      pushState(T_ILLEGAL, 1'b0);
      drainQueue("trapOpIgnored", 1'b0);
      checkOutput("trapCount", obsCnt, 32'd0);

      $display("[TB] directed sequence complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
